// File: rtl/block_map_ctrl.sv
// block_map_ctrl: fully associative block-address -> SRAM-slot map. It chooses
// a free slot first and falls back to LRU, tracks dirty slots, and runs one swap at a time.

module block_map_lookup #(
    parameter int NumSlots  = 4,
    parameter int AddrWidth = 21,
    parameter int SlotW     = 2
) (
    input  logic                               lookup_i,
    input  logic [AddrWidth-1:0]               addr_i,
    input  logic [NumSlots-1:0]                entry_vld_i,
    input  logic [NumSlots-1:0][AddrWidth-1:0] tag_i,
    output logic                               hit_o,
    output logic [SlotW-1:0]                   slot_o
);
    // Valid tags are unique, so scan order only matters for the '0 default.
    always_comb begin
        hit_o  = 1'b0;
        slot_o = '0;
        for (int s = NumSlots - 1; s >= 0; s--) begin
            if (lookup_i && entry_vld_i[s] && (tag_i[s] == addr_i)) begin
                hit_o  = 1'b1;
                slot_o = SlotW'(s);
            end
        end
    end
endmodule

module block_map_ctrl #(
    parameter int NumReq    = 2,
    parameter int NumSlots  = 4,
    parameter int AddrWidth = 21,
    parameter int SlotW     = $clog2(NumSlots),
    parameter int CntW      = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumReq-1:0][AddrWidth-1:0]  req_addr_i,
    input  logic [NumReq-1:0]                 valid_i,
    input  logic [NumReq-1:0]                 we_i,
    output logic [NumReq-1:0][SlotW-1:0]      slot_idx_o,
    output logic                              block_o,
    input  logic                              enable_i,
    input  logic                              only_load_i,
    input  logic                              flush_i,
    output logic                              swap_req_o,
    output logic [SlotW-1:0]                  swap_slot_o,
    output logic [AddrWidth-1:0]              old_addr_o,
    output logic [AddrWidth-1:0]              new_addr_o,
    output logic                              writeback_o,
    input  logic                              swap_done_i,
    output logic                              busy_o,
    output logic [CntW-1:0]                   miss_cnt_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, UPDATE} state_e;
    typedef logic [NumSlots-1:0][SlotW-1:0] age_t;

    state_e                             state_q, state_d;
    logic [NumSlots-1:0]                valid_q, valid_d, dirty_q, dirty_d;
    logic [NumSlots-1:0][AddrWidth-1:0] tag_q, tag_d;
    age_t                               age_q, age_d;
    logic [SlotW-1:0]                   swap_slot_q, swap_slot_d;
    logic [AddrWidth-1:0]               old_addr_q, old_addr_d, new_addr_q, new_addr_d;
    logic                               writeback_q, writeback_d;
    logic [CntW-1:0]                    miss_cnt_q, miss_cnt_d;

    logic [NumReq-1:0]                  hit, miss;
    logic [NumReq-1:0][SlotW-1:0]       hit_slot;
    logic [SlotW-1:0]                   victim, touch_slot;
    logic [AddrWidth-1:0]               miss_addr;

    function automatic age_t init_ages();
        age_t r;
        for (int i = 0; i < NumSlots; i++) r[i] = SlotW'(i);
        return r;
    endfunction

    // Move slot s to most-recent; everything younger than it ages by one.
    function automatic age_t touch(input age_t a, input logic [SlotW-1:0] s);
        age_t r;
        r = a;
        for (int i = 0; i < NumSlots; i++) begin
            if (a[i] < a[s]) r[i] = a[i] + SlotW'(1);
        end
        r[s] = '0;
        return r;
    endfunction

    for (genvar p = 0; p < NumReq; p++) begin : g_port
        block_map_lookup #(
            .NumSlots (NumSlots),
            .AddrWidth(AddrWidth),
            .SlotW    (SlotW)
        ) u_lookup (
            .lookup_i   (valid_i[p] & enable_i),
            .addr_i     (req_addr_i[p]),
            .entry_vld_i(valid_q),
            .tag_i      (tag_q),
            .hit_o      (hit[p]),
            .slot_o     (hit_slot[p])
        );
        assign miss[p]       = valid_i[p] & enable_i & ~hit[p];
        assign slot_idx_o[p] = hit_slot[p];
    end

    // Lowest-index free slot wins over the LRU slot; lowest-index port wins.
    always_comb begin
        victim = '0;
        for (int s = 0; s < NumSlots; s++) begin
            if (age_q[s] == SlotW'(NumSlots - 1)) victim = SlotW'(s);
        end
        for (int s = NumSlots - 1; s >= 0; s--) begin
            if (!valid_q[s]) victim = SlotW'(s);
        end
        miss_addr  = '0;
        touch_slot = '0;
        for (int p = NumReq - 1; p >= 0; p--) begin
            if (miss[p]) miss_addr = req_addr_i[p];
            if (hit[p])  touch_slot = hit_slot[p];
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        age_d       = age_q;
        swap_slot_d = swap_slot_q;
        old_addr_d  = old_addr_q;
        new_addr_d  = new_addr_q;
        writeback_d = writeback_q;
        miss_cnt_d  = miss_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    valid_d    = '0;
                    dirty_d    = '0;
                    age_d      = init_ages();
                    miss_cnt_d = '0;
                end else begin
                    // Hits are only possible while enabled, so disabled mode leaves the table alone.
                    if (|hit) age_d = touch(age_q, touch_slot);
                    for (int p = 0; p < NumReq; p++) begin
                        if (hit[p] && we_i[p]) dirty_d[hit_slot[p]] = 1'b1;
                    end
                    if (|miss) begin
                        swap_slot_d = victim;
                        new_addr_d  = miss_addr;
                        old_addr_d  = valid_q[victim] ? tag_q[victim] : '0;
                        writeback_d = valid_q[victim] & dirty_q[victim] & ~only_load_i;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CntW'(1);
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (swap_done_i) state_d = UPDATE;
            end
            UPDATE: begin
                valid_d[swap_slot_q] = 1'b1;
                dirty_d[swap_slot_q] = 1'b0;
                tag_d[swap_slot_q]   = new_addr_q;
                age_d                = touch(age_q, swap_slot_q);
                state_d              = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            tag_q       <= '0;
            age_q       <= init_ages();
            swap_slot_q <= '0;
            old_addr_q  <= '0;
            new_addr_q  <= '0;
            writeback_q <= 1'b0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            tag_q       <= tag_d;
            age_q       <= age_d;
            swap_slot_q <= swap_slot_d;
            old_addr_q  <= old_addr_d;
            new_addr_q  <= new_addr_d;
            writeback_q <= writeback_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign swap_req_o  = (state_q == ISSUE);
    assign block_o     = busy_o | (|miss);
    assign swap_slot_o = swap_slot_q;
    assign old_addr_o  = old_addr_q;
    assign new_addr_o  = new_addr_q;
    assign writeback_o = writeback_q;
    assign miss_cnt_o  = miss_cnt_q;
endmodule

// File: tb/tb_block_map_ctrl.sv
// Directed bench for block_map_ctrl: expected swaps go into a scoreboard queue,
// and a monitor pops and compares them each time swap_req_o rises.

module tb_block_map_ctrl;
    localparam int AW = 21;
    localparam int SW = 2;

    typedef struct packed {
        logic [SW-1:0] slot;
        logic [AW-1:0] old_a;
        logic [AW-1:0] new_a;
        logic          wb;
    } swap_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0][AW-1:0]   req_addr;
    logic [1:0]           valid, we;
    logic [1:0][SW-1:0]   slot_idx;
    logic                 block_o, enable, only_load, flush;
    logic                 swap_req_o, writeback_o, busy_o;
    logic [SW-1:0]        swap_slot_o;
    logic [AW-1:0]        old_addr_o, new_addr_o;
    logic [15:0]          miss_cnt_o;
    logic                 resp_done = 1'b0, man_done = 1'b0, auto_done = 1'b1;
    logic                 swap_done;
    logic                 req_prev = 1'b0;
    int                   rcnt = 0;
    int                   total = 0, bad = 0;
    swap_t                exp_q[$];

    assign swap_done = resp_done | man_done;

    block_map_ctrl #(.NumReq(2), .NumSlots(4), .AddrWidth(AW), .CntW(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_addr_i(req_addr), .valid_i(valid), .we_i(we),
        .slot_idx_o(slot_idx), .block_o(block_o), .enable_i(enable), .only_load_i(only_load),
        .flush_i(flush), .swap_req_o(swap_req_o), .swap_slot_o(swap_slot_o),
        .old_addr_o(old_addr_o), .new_addr_o(new_addr_o), .writeback_o(writeback_o),
        .swap_done_i(swap_done), .busy_o(busy_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Swap engine model: done pulse on the third cycle of a request.
    always @(negedge clk) begin
        if (auto_done && swap_req_o && !resp_done) begin
            rcnt++;
            if (rcnt == 3) begin
                resp_done = 1'b1;
                rcnt = 0;
            end
        end else begin
            resp_done = 1'b0;
            rcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (swap_req_o && !req_prev) begin
            if (exp_q.size() == 0) chk("swap_unexpected", 64'(1), 64'(0));
            else chk("swap_fields", 64'({swap_slot_o, old_addr_o, new_addr_o, writeback_o}),
                     64'(exp_q.pop_front()));
        end
        req_prev = swap_req_o;
    end

    task automatic wait_clear(output int cyc);
        cyc = -1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!block_o) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
        if (cyc < 0) chk("block_timeout", 64'(1), 64'(0));
    endtask

    task automatic hit_req(input int p, input logic [AW-1:0] a, input logic w,
                           input logic [SW-1:0] es);
        int cyc;
        @(negedge clk);
        req_addr[p] = a; valid[p] = 1'b1; we[p] = w;
        wait_clear(cyc);
        chk("hit_latency", 64'(cyc), 64'(0));
        chk("hit_slot", 64'(slot_idx[p]), 64'(es));
        @(negedge clk);
        valid[p] = 1'b0; we[p] = 1'b0;
    endtask

    task automatic miss_req(input int p, input logic [AW-1:0] a, input logic [SW-1:0] vs,
                            input logic [AW-1:0] old_a, input logic wb);
        int cyc;
        exp_q.push_back({vs, old_a, a, wb});
        @(negedge clk);
        req_addr[p] = a; valid[p] = 1'b1; we[p] = 1'b0;
        #1;
        chk("miss_block_comb", 64'(block_o), 64'(1));
        chk("miss_busy_early", 64'(busy_o), 64'(0));
        wait_clear(cyc);
        chk("miss_latency", 64'(cyc), 64'(5));
        chk("fill_hit_slot", 64'(slot_idx[p]), 64'(vs));
        @(negedge clk);
        valid[p] = 1'b0;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0; req_addr = '0; valid = '0; we = '0;
        enable = 1'b1; only_load = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_swap_req", 64'(swap_req_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_block", 64'(block_o), 64'(0));
        chk("rst_miss_cnt", 64'(miss_cnt_o), 64'(0));
        chk("rst_swap_regs", 64'({swap_slot_o, old_addr_o, new_addr_o, writeback_o}), 64'(0));
        rst_n = 1'b1;

        // Cold fill: free slots taken in index order.
        miss_req(0, 21'h100, 2'd0, 21'h0, 1'b0);
        miss_req(0, 21'h200, 2'd1, 21'h0, 1'b0);
        miss_req(0, 21'h300, 2'd2, 21'h0, 1'b0);
        miss_req(0, 21'h400, 2'd3, 21'h0, 1'b0);
        chk("cold_miss_cnt", 64'(miss_cnt_o), 64'(4));
        hit_req(0, 21'h200, 1'b0, 2'd1);

        // LRU eviction.
        hit_req(0, 21'h100, 1'b0, 2'd0);
        hit_req(0, 21'h300, 1'b0, 2'd2);
        hit_req(0, 21'h400, 1'b0, 2'd3);
        miss_req(0, 21'h500, 2'd1, 21'h200, 1'b0);

        // Dirty victim is written back.
        hit_req(1, 21'h500, 1'b1, 2'd1);
        hit_req(0, 21'h100, 1'b0, 2'd0);
        hit_req(0, 21'h400, 1'b0, 2'd3);
        hit_req(0, 21'h300, 1'b0, 2'd2);
        miss_req(0, 21'h600, 2'd1, 21'h500, 1'b1);

        // Dirty victim with only_load suppresses writeback.
        hit_req(0, 21'h600, 1'b1, 2'd1);
        hit_req(0, 21'h100, 1'b0, 2'd0);
        hit_req(0, 21'h300, 1'b0, 2'd2);
        hit_req(0, 21'h400, 1'b0, 2'd3);
        only_load = 1'b1;
        miss_req(0, 21'h700, 2'd1, 21'h600, 1'b0);
        only_load = 1'b0;
        // Clean victim.
        miss_req(0, 21'h800, 2'd0, 21'h100, 1'b0);
        chk("miss_cnt_8", 64'(miss_cnt_o), 64'(8));

        // Simultaneous misses: port0 first, then port1.
        exp_q.push_back({2'd2, 21'h300, 21'h900, 1'b0});
        exp_q.push_back({2'd3, 21'h400, 21'hA00, 1'b0});
        @(negedge clk);
        req_addr[0] = 21'h900; req_addr[1] = 21'hA00; valid = 2'b11;
        wait_clear(cyc);
        chk("dual_block_cycles", 64'(cyc), 64'(10));
        chk("dual_slots", 64'(slot_idx), 64'({2'd3, 2'd2}));
        chk("dual_miss_cnt", 64'(miss_cnt_o), 64'(10));
        @(negedge clk);
        valid = 2'b00;

        // swap_done in IDLE is ignored.
        @(negedge clk); man_done = 1'b1;
        @(negedge clk); man_done = 1'b0;
        #1;
        chk("done_idle_busy", 64'(busy_o), 64'(0));
        chk("done_idle_req", 64'(swap_req_o), 64'(0));
        chk("done_idle_cnt", 64'(miss_cnt_o), 64'(10));

        // flush during ISSUE is ignored.
        auto_done = 1'b0;
        exp_q.push_back({2'd1, 21'h700, 21'hB00, 1'b0});
        @(negedge clk);
        req_addr[0] = 21'hB00; valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1;
        chk("flush_issue_busy", 64'(busy_o), 64'(1));
        chk("flush_issue_req", 64'(swap_req_o), 64'(1));
        auto_done = 1'b1;
        wait_clear(cyc);
        chk("flush_issue_slot", 64'(slot_idx[0]), 64'(1));
        chk("flush_issue_cnt", 64'(miss_cnt_o), 64'(11));
        @(negedge clk);
        valid[0] = 1'b0;
        hit_req(1, 21'h900, 1'b0, 2'd2);

        // flush in IDLE: table and counter cleared.
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1;
        chk("flush_cnt", 64'(miss_cnt_o), 64'(0));
        exp_q.push_back({2'd0, 21'h0, 21'h900, 1'b0});
        exp_q.push_back({2'd1, 21'h0, 21'h800, 1'b0});
        @(negedge clk);
        req_addr[0] = 21'h900; req_addr[1] = 21'h800; valid = 2'b11;
        wait_clear(cyc);
        chk("flush_refill_cycles", 64'(cyc), 64'(10));
        chk("flush_refill_slots", 64'(slot_idx), 64'({2'd1, 2'd0}));
        chk("flush_refill_cnt", 64'(miss_cnt_o), 64'(2));
        @(negedge clk);
        valid = 2'b00;

        // Disabled mode: no blocking, no slot indices, no counting.
        @(negedge clk);
        enable = 1'b0; req_addr[0] = 21'h1DEAD; req_addr[1] = 21'h800; valid = 2'b11;
        #1;
        chk("dis_block", 64'(block_o), 64'(0));
        chk("dis_slots", 64'(slot_idx), 64'(0));
        repeat (3) @(negedge clk);
        #1;
        chk("dis_cnt", 64'(miss_cnt_o), 64'(2));
        chk("dis_busy", 64'(busy_o), 64'(0));
        @(negedge clk);
        valid = 2'b00; enable = 1'b1;

        // Async reset during ISSUE drops the request at once.
        auto_done = 1'b0;
        exp_q.push_back({2'd2, 21'h0, 21'hC00, 1'b0});
        @(negedge clk);
        req_addr[0] = 21'hC00; valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_mid_req_before", 64'(swap_req_o), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req", 64'(swap_req_o), 64'(0));
        chk("rst_mid_busy", 64'(busy_o), 64'(0));
        chk("rst_mid_cnt", 64'(miss_cnt_o), 64'(0));
        @(negedge clk);
        valid = 2'b00; rst_n = 1'b1; auto_done = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_block", 64'(block_o), 64'(0));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/block_map_ctrl.md
# block_map_ctrl

Parametrised successor to the request-blocker controller: a fully associative block-mapping table that maps external block addresses from `NumReq` requesters onto `NumSlots` SRAM slots. It stalls requesters on a miss, picks a victim slot (free slot first, else LRU), and issues one swap request at a time to the block-swap engine. It adds dirty tracking, so clean victims skip writeback, plus a flush and a miss counter. It sits in the user domain between the core-side request blockers and `block_swap_ctrl`.

## Interface
Parameters:
- `NumReq`, 2: number of requester ports.
- `NumSlots`, 4: SRAM slots (power of two, ≥2).
- `AddrWidth`, 21: block address width.
- `SlotW`, `$clog2(NumSlots)`: derived; slot index width.
- `CntW`, 16: miss counter width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_addr_i`  in  NumReq×AddrWidth  requested block address per port.
- `valid_i`  in  NumReq  request valid per port.
- `we_i`  in  NumReq  request is a write (marks slot dirty on hit).
- `slot_idx_o`  out  NumReq×SlotW  hit slot per port; '0 on miss or when disabled.
- `block_o`  out  1  stall all requesters.
- `enable_i`  in  1  mapping enabled (block_swap_on).
- `only_load_i`  in  1  suppress writeback of dirty victims.
- `flush_i`  in  1  invalidate table (pulse).
- `swap_req_o`  out  1  swap request, held until done.
- `swap_slot_o`  out  SlotW  victim slot.
- `old_addr_o`  out  AddrWidth  victim tag ('0 if victim invalid).
- `new_addr_o`  out  AddrWidth  address to load.
- `writeback_o`  out  1  victim must be written back.
- `swap_done_i`  in  1  swap engine completion pulse.
- `busy_o`  out  1  FSM not in IDLE.
- `miss_cnt_o`  out  CntW  saturating miss count.

## Operation
- Table: per slot {valid, dirty, tag, age[SlotW]}. Tags are unique among valid entries.
- Lookup (combinational): port p hits if `valid_i[p]` & `enable_i` & there is a valid entry with tag == `req_addr_i[p]`; `slot_idx_o[p]` = that slot.
- `block_o = busy_o | (enable_i & any valid port misses)`. When `enable_i`=0 and the FSM is IDLE: `block_o`=0, all `slot_idx_o`='0, and no table updates.
- LRU: ages form a permutation of 0..NumSlots-1 (reset: age = slot index). Touching slot s: entries with age < age[s] increment, and age[s] becomes 0. Touch occurs on the lowest-index hitting port in IDLE each cycle, and on fill.
- Dirty: set on a hit with `we_i[p]` (any port, IDLE only); cleared on fill.
- FSM states:
  - IDLE:
    - `flush_i` takes priority: clear all valid/dirty bits, reset ages to index, clear `miss_cnt_o`, issue no swap this cycle.
    - Else, on any miss, take the lowest-index missing port m. Victim is the lowest-index invalid slot, else the slot with age NumSlots-1.
    - Register `swap_slot_o`, `new_addr_o`=`req_addr_i[m]`, `old_addr_o`, and `writeback_o` = victim.valid & victim.dirty & !`only_load_i`.
    - Increment `miss_cnt_o` (saturating at all-ones) and move to ISSUE.
  - ISSUE: `swap_req_o`=1 with all swap outputs stable. Move to UPDATE on `swap_done_i`.
  - UPDATE: write the victim entry as {valid=1, dirty=0, tag=new_addr}, touch it for LRU, and return to IDLE.
- `swap_done_i` outside ISSUE is ignored. `flush_i` outside IDLE is ignored.
- `enable_i` falling mid-swap: the swap completes normally and the table is still updated.
- Two ports missing on the same address: only one swap is issued; both hit afterward.

## Timing
- Reset values: FSM IDLE; `swap_req_o`=0, `swap_slot_o`='0, `old_addr_o`='0, `new_addr_o`='0, `writeback_o`=0, `busy_o`=0, `miss_cnt_o`=0; table all invalid and clean.
- Async reset mid-swap returns to IDLE immediately and discards the in-flight swap.
- Miss visible in cycle 0 → `swap_req_o`=1 from cycle 1.
- `swap_done_i` sampled high in cycle k → UPDATE in k+1 → IDLE, hit, and `block_o`=0 in k+2 (if no other misses).
- `block_o` rises combinationally in the cycle the miss appears.
- `busy_o` is registered: high from cycle 1 through UPDATE.

## Test plan
- Cold fill, NumSlots=4:
  - Stimulus: port0 requests 0x100, 0x200, 0x300, 0x400 in turn, `swap_done_i` after 3 cycles each.
  - Expected: victims are slots 0,1,2,3; `old_addr_o`=0 and `writeback_o`=0 each time; `miss_cnt_o`=4; re-requesting 0x200 hits slot 1 with `block_o`=0.
- LRU eviction:
  - Stimulus: after cold fill, touch 0x100, 0x300, 0x400, then request 0x500.
  - Expected: victim is slot 1, `old_addr_o`=0x200.
- Dirty writeback:
  - Stimulus: write-hit on slot 1, then force its eviction.
  - Expected: `writeback_o`=1. Repeating with `only_load_i`=1 gives `writeback_o`=0; a clean victim gives 0.
- Simultaneous misses:
  - Stimulus: port0=0x600 and port1=0x700 miss in the same cycle.
  - Expected: swap for 0x600 first, then 0x700; `block_o` stays high until the second UPDATE+1.
- Protocol edges:
  - `swap_done_i` pulsed in IDLE → no state change.
  - `flush_i` during ISSUE → ignored.
  - `flush_i` in IDLE → all ports miss afterward and `miss_cnt_o`=0.
  - `rst_ni` low in ISSUE → `swap_req_o`=0 immediately.
- Disabled mode: with `enable_i`=0 and `valid_i`=all ones → `block_o`=0, all `slot_idx_o`=0, and `miss_cnt_o` unchanged.
